// File: rtl/draw_sched_pkg.sv
// Shared constants, state encoding and the on-screen test for the draw scheduler.
package draw_sched_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOR_W  = 3;
  localparam int DIM_W    = 4;

  localparam logic [COLOR_W-1:0] COLOR_BG    = 3'b111;
  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the widened pixel address lies inside the visible frame.
  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_scheduler_rect_walker.sv
// rect_walker: raster walk of one latched rectangle, one pixel per non-held cycle.
// Addresses are formed one bit wider than the frame coordinates so off-screen
// pixels can be suppressed while the walk still advances.
module rect_walker
  import draw_sched_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_active,
  input  logic               i_hold,
  input  logic [X_W-1:0]     i_x0,
  input  logic [Y_W-1:0]     i_y0,
  input  logic [DIM_W-1:0]   i_w,
  input  logic [DIM_W-1:0]   i_h,
  input  logic [COLOR_W-1:0] i_color,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_plot,
  output logic               o_finished
);

  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic [DIM_W-1:0]   r_w;
  logic [DIM_W-1:0]   r_h;
  logic [COLOR_W-1:0] r_color;
  logic [DIM_W-1:0]   r_xc;
  logic [DIM_W-1:0]   r_yc;
  logic               r_fin;
  logic [X_W-1:0]     r_xout;
  logic [Y_W-1:0]     r_yout;
  logic [COLOR_W-1:0] r_cout;
  logic               r_plot;

  logic [X_W:0]       w_sum_x;
  logic [Y_W:0]       w_sum_y;
  logic               w_adv;
  logic               w_last;

  assign w_sum_x = {1'b0, r_x0} + {{(X_W+1-DIM_W){1'b0}}, r_xc};
  assign w_sum_y = {1'b0, r_y0} + {{(Y_W+1-DIM_W){1'b0}}, r_yc};
  assign w_adv   = i_active && !i_hold && !r_fin;
  assign w_last  = (r_xc == r_w) && (r_yc == r_h);

  // Latch a new job on start, otherwise emit the current pixel and step the counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_xc    <= '0;
      r_yc    <= '0;
      r_fin   <= 1'b0;
      r_xout  <= '0;
      r_yout  <= '0;
      r_cout  <= '0;
      r_plot  <= 1'b0;
    end else if (i_start) begin
      r_x0    <= i_x0;
      r_y0    <= i_y0;
      r_w     <= i_w;
      r_h     <= i_h;
      r_color <= i_color;
      r_xc    <= '0;
      r_yc    <= '0;
      r_fin   <= 1'b0;
      r_plot  <= 1'b0;
    end else if (w_adv) begin
      r_xout <= w_sum_x[X_W-1:0];
      r_yout <= w_sum_y[Y_W-1:0];
      r_cout <= r_color;
      r_plot <= on_screen(w_sum_x, w_sum_y);
      if (w_last) begin
        r_fin <= 1'b1;
      end else if (r_xc == r_w) begin
        r_xc <= '0;
        r_yc <= r_yc + DIM_W'(1);
      end else begin
        r_xc <= r_xc + DIM_W'(1);
      end
    end else begin
      r_plot <= 1'b0;
    end
  end

  assign o_x        = r_xout;
  assign o_y        = r_yout;
  assign o_color    = r_cout;
  assign o_plot     = r_plot;
  assign o_finished = r_fin;

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates rectangle-fill jobs from N_REQ clients and owns the
// single frame-buffer pixel write port.
// Optional feature macro: DRAW_SCHED_RR_EN (round-robin instead of fixed priority).
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int N_REQ = 3
)
(
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         Req,
  input  logic [N_REQ*X_W-1:0]     ReqX,
  input  logic [N_REQ*Y_W-1:0]     ReqY,
  input  logic [N_REQ*DIM_W-1:0]   ReqW,
  input  logic [N_REQ*DIM_W-1:0]   ReqH,
  input  logic [N_REQ*COLOR_W-1:0] ReqColor,
  input  logic                     Hold,
  output logic [N_REQ-1:0]         Grant,
  output logic [N_REQ-1:0]         Done,
  output logic                     Busy,
  output logic [X_W-1:0]           XOut,
  output logic [Y_W-1:0]           YOut,
  output logic [COLOR_W-1:0]       Color,
  output logic                     Plot
);

  localparam int             IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_REQ_L = (IDX_W+1)'(N_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic [N_REQ-1:0]   r_done;
  logic [N_REQ-1:0]   w_done_nxt;
  logic               r_busy;
  logic [IDX_W-1:0]   r_win;
  logic [IDX_W-1:0]   w_win_nxt;
  logic [IDX_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W:0]     w_cand;
  logic               w_found;
  logic               w_start;
  logic               w_finished;
  logic [N_REQ-1:0]   w_onehot;
  logic [X_W-1:0]     w_sel_x;
  logic [Y_W-1:0]     w_sel_y;
  logic [DIM_W-1:0]   w_sel_w;
  logic [DIM_W-1:0]   w_sel_h;
  logic [COLOR_W-1:0] w_sel_c;

`ifdef DRAW_SCHED_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;

  // Move the search start just past the client that has just finished.
  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (r_state == DONE) begin
      if (r_win == IDX_W'(N_REQ - 1)) begin
        w_rr_nxt = '0;
      end else begin
        w_rr_nxt = r_win + IDX_W'(1);
      end
    end else begin
      w_rr_nxt = r_rr_ptr;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
    end
  end

  assign w_base = r_rr_ptr;
`else
  assign w_base = '0;
`endif

  // Scan requests starting at w_base (wrapping) and take the first one set.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, w_base} + (IDX_W+1)'(i);
      if (w_cand >= N_REQ_L) begin
        w_cand = w_cand - N_REQ_L;
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && Req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_sel_x  = ReqX[int'(w_pick) * X_W +: X_W];
  assign w_sel_y  = ReqY[int'(w_pick) * Y_W +: Y_W];
  assign w_sel_w  = ReqW[int'(w_pick) * DIM_W +: DIM_W];
  assign w_sel_h  = ReqH[int'(w_pick) * DIM_W +: DIM_W];
  assign w_sel_c  = ReqColor[int'(w_pick) * COLOR_W +: COLOR_W];

  // Next-state and next-output logic of the job FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_win_nxt   = r_win;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_win_nxt   = w_pick;
          w_grant_nxt = w_onehot;
          w_state_nxt = FILL;
        end else begin
          w_grant_nxt = '0;
        end
      end
      FILL: begin
        if (w_finished) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = FILL;
        end
      end
      DONE: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_win   <= w_win_nxt;
    end
  end

  rect_walker u_walker (
    .i_clk      (Clock),
    .i_rst_n    (Reset),
    .i_start    (w_start),
    .i_active   (r_state == FILL),
    .i_hold     (Hold),
    .i_x0       (w_sel_x),
    .i_y0       (w_sel_y),
    .i_w        (w_sel_w),
    .i_h        (w_sel_h),
    .i_color    (w_sel_c),
    .o_x        (XOut),
    .o_y        (YOut),
    .o_color    (Color),
    .o_plot     (Plot),
    .o_finished (w_finished)
  );

  assign Grant = r_grant;
  assign Done  = r_done;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a job-level model built from pixel queues.
module tb_draw_scheduler;

  localparam int N = 3;

  logic          Clock;
  logic          Reset;
  logic [N-1:0]  Req;
  logic [N*8-1:0] ReqX;
  logic [N*7-1:0] ReqY;
  logic [N*4-1:0] ReqW;
  logic [N*4-1:0] ReqH;
  logic [N*3-1:0] ReqColor;
  logic          Hold;
  logic [N-1:0]  Grant;
  logic [N-1:0]  Done;
  logic          Busy;
  logic [7:0]    XOut;
  logic [6:0]    YOut;
  logic [2:0]    Color;
  logic          Plot;

  draw_scheduler #(.N_REQ(N)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqX(ReqX), .ReqY(ReqY),
    .ReqW(ReqW), .ReqH(ReqH), .ReqColor(ReqColor), .Hold(Hold),
    .Grant(Grant), .Done(Done), .Busy(Busy), .XOut(XOut), .YOut(YOut),
    .Color(Color), .Plot(Plot)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] exp_grant = '0;
  logic [N-1:0] exp_done  = '0;
  logic         exp_busy  = 1'b0;
  logic         exp_plot  = 1'b0;
  logic [7:0]   exp_x     = '0;
  logic [6:0]   exp_y     = '0;
  logic [2:0]   exp_c     = '0;
  int qx[$];
  int qy[$];
  int m_stage = 0;   // 0 waiting, 1 walking, 2 last pixel out, 3 done pulse
  int m_win   = 0;
  int m_ptr   = 0;
  logic [2:0] m_col;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int start;
`ifdef DRAW_SCHED_RR_EN
    start = ptr;
`else
    start = ptr * 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return 0;
  endfunction

  // Job-level reference: pixel list built at grant, one popped per free cycle.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      exp_grant = '0; exp_done = '0; exp_busy = 1'b0; exp_plot = 1'b0;
      exp_x = '0; exp_y = '0; exp_c = '0;
      qx.delete(); qy.delete();
      m_stage = 0; m_ptr = 0; m_win = 0;
    end else begin
      case (m_stage)
        0: if (Req != '0) begin
          int x0, y0, w, h;
          m_win = pick(Req, m_ptr);
          x0 = int'(ReqX[8*m_win +: 8]);
          y0 = int'(ReqY[7*m_win +: 7]);
          w  = int'(ReqW[4*m_win +: 4]);
          h  = int'(ReqH[4*m_win +: 4]);
          m_col = ReqColor[3*m_win +: 3];
          for (int yy = 0; yy <= h; yy++)
            for (int xx = 0; xx <= w; xx++) begin
              qx.push_back(x0 + xx);
              qy.push_back(y0 + yy);
            end
          exp_grant = N'(1) << m_win;
          exp_busy  = 1'b1;
          m_stage   = 1;
        end
        1: if (!Hold) begin
          int px, py;
          px = qx.pop_front();
          py = qy.pop_front();
          exp_x    = 8'(px % 256);
          exp_y    = 7'(py % 128);
          exp_c    = m_col;
          exp_plot = (px < 160) && (py < 120);
          if (qx.size() == 0) m_stage = 2;
        end else begin
          exp_plot = 1'b0;
        end
        2: begin
          exp_plot  = 1'b0;
          exp_done  = N'(1) << m_win;
          exp_grant = '0;
          m_stage   = 3;
        end
        default: begin
          exp_done = '0;
          exp_busy = 1'b0;
          m_ptr    = (m_win + 1) % N;
          m_stage  = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    chk("grant", 32'(Grant), 32'(exp_grant));
    chk("done",  32'(Done),  32'(exp_done));
    chk("busy",  32'(Busy),  32'(exp_busy));
    chk("plot",  32'(Plot),  32'(exp_plot));
    chk("xout",  32'(XOut),  32'(exp_x));
    chk("yout",  32'(YOut),  32'(exp_y));
    chk("color", 32'(Color), 32'(exp_c));
  end

  // ---------------- observation of DUT activity ----------------
  int cyc = 0, grant_cyc = 0, done_cyc = 0, plot_cnt = 0;
  int fx = 0, fy = 0, lx = 0, ly = 0, rx = 0, ry = 0;
  int glist[$];
  logic [N-1:0] prev_grant = '0;

  // Record plot counts, key pixel positions and grant/done timing.
  always @(negedge Clock) begin
    cyc++;
    if (Grant != '0 && prev_grant == '0) begin
      grant_cyc = cyc;
      for (int i = 0; i < N; i++) if (Grant[i]) glist.push_back(i);
    end
    if (Done != '0) done_cyc = cyc;
    if (Plot) begin
      if (plot_cnt == 0) begin fx = int'(XOut); fy = int'(YOut); end
      if (plot_cnt == 8) begin rx = int'(XOut); ry = int'(YOut); end
      lx = int'(XOut); ly = int'(YOut);
      plot_cnt++;
    end
    prev_grant = Grant;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic set_job(input int c, input int x, input int y, input int w, input int h, input int col);
    ReqX[8*c +: 8]     = 8'(x);
    ReqY[7*c +: 7]     = 7'(y);
    ReqW[4*c +: 4]     = 4'(w);
    ReqH[4*c +: 4]     = 4'(h);
    ReqColor[3*c +: 3] = 3'(col);
  endtask

  task automatic clear_obs();
    plot_cnt = 0;
    glist.delete();
  endtask

  task automatic wait_done(input int budget, output logic [N-1:0] d);
    int n;
    n = 0;
    while (Done == '0 && n < budget) begin
      tick();
      n++;
    end
    d = Done;
    chk("done_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_busy || Busy) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n >= budget), 32'd0);
    tick();
  endtask

  // ---------------- test sequence ----------------
  logic [N-1:0] d;

  initial begin
    Reset = 1'b0; Req = '0; Hold = 1'b0;
    ReqX = '0; ReqY = '0; ReqW = '0; ReqH = '0; ReqColor = '0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();

    // Single job 9x5 at (6,102)
    clear_obs();
    set_job(0, 6, 102, 8, 4, 7);
    Req = 3'b001;
    tick();
    chk("single_grant", 32'(Grant), 32'd1);
    wait_done(200, d);
    Req = '0;
    chk("single_done_who", 32'(d), 32'd1);
    chk("single_plots", 32'(plot_cnt), 32'd45);
    chk("single_first_x", 32'(fx), 32'd6);
    chk("single_first_y", 32'(fy), 32'd102);
    chk("single_rowend_x", 32'(rx), 32'd14);
    chk("single_rowend_y", 32'(ry), 32'd102);
    chk("single_last_x", 32'(lx), 32'd14);
    chk("single_last_y", 32'(ly), 32'd106);
    chk("single_latency", 32'(done_cyc - grant_cyc), 32'd46);
    wait_idle(20);

    // Clipping at the bottom-right corner
    clear_obs();
    set_job(0, 155, 118, 15, 3, 2);
    Req = 3'b001;
    wait_done(200, d);
    Req = '0;
    chk("clip_plots", 32'(plot_cnt), 32'd10);
    chk("clip_latency", 32'(done_cyc - grant_cyc), 32'd65);
    wait_idle(20);

    // Two 1x1 clients held high
    clear_obs();
    set_job(0, 1, 1, 0, 0, 1);
    set_job(1, 2, 2, 0, 0, 4);
    Req = 3'b011;
    for (int n = 0; n < 60 && glist.size() < 4; n++) tick();
    Req = '0;
    chk("arb_count", 32'(glist.size()), 32'd4);
    if (glist.size() >= 4) begin
      chk("arb_g0", 32'(glist[0]), 32'd0);
`ifdef DRAW_SCHED_RR_EN
      chk("arb_g1", 32'(glist[1]), 32'd1);
      chk("arb_g2", 32'(glist[2]), 32'd0);
      chk("arb_g3", 32'(glist[3]), 32'd1);
`else
      chk("arb_g1", 32'(glist[1]), 32'd0);
      chk("arb_g2", 32'(glist[2]), 32'd0);
      chk("arb_g3", 32'(glist[3]), 32'd0);
`endif
    end
    wait_idle(40);

    // Hold for three cycles after the second pixel of a 4x1 job
    clear_obs();
    set_job(0, 40, 50, 3, 0, 5);
    Req = 3'b001;
    for (int n = 0; n < 20 && plot_cnt < 2; n++) tick();
    Hold = 1'b1;
    repeat (3) tick();
    Hold = 1'b0;
    wait_done(40, d);
    Req = '0;
    chk("hold_plots", 32'(plot_cnt), 32'd4);
    chk("hold_latency", 32'(done_cyc - grant_cyc), 32'd8);
    chk("hold_last_x", 32'(lx), 32'd43);
    chk("hold_last_y", 32'(ly), 32'd50);
    wait_idle(20);

    // Client 1 drops its request right after grant
    clear_obs();
    set_job(1, 10, 10, 2, 2, 3);
    Req = 3'b010;
    tick();
    chk("drop_grant", 32'(Grant), 32'd2);
    Req = '0;
    wait_done(40, d);
    chk("drop_done_who", 32'(d), 32'd2);
    chk("drop_plots", 32'(plot_cnt), 32'd9);
    wait_idle(20);

    // Reset in the middle of a 9x5 job, client 2 keeps requesting
    set_job(2, 20, 30, 8, 4, 6);
    Req = 3'b100;
    repeat (10) tick();
    #1 Reset = 1'b0;
    #1;
    chk("async_reset", {22'd0, Grant, Done, Busy, Plot, XOut, YOut, Color} , 32'd0);
    tick();
    clear_obs();
    Reset = 1'b1;
    tick();
    chk("rearm_grant", 32'(Grant), 32'd4);
    wait_done(100, d);
    Req = '0;
    chk("rearm_plots", 32'(plot_cnt), 32'd45);
    chk("rearm_first_x", 32'(fx), 32'd20);
    chk("rearm_first_y", 32'(fy), 32'd30);
    wait_idle(20);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      tick();
      Hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!Req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_job(i, int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
            Req[i] = 1'b1;
          end
        end else if (exp_done[i] && $urandom_range(0, 1) == 0) begin
          Req[i] = 1'b0;
        end else if (exp_grant[i] && $urandom_range(0, 15) == 0) begin
          Req[i] = 1'b0;
        end
      end
    end
    Req = '0;
    Hold = 1'b0;
    wait_idle(400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Arbitrated rectangle-fill engine that owns the single pixel-write port into the VGA frame buffer. Up to N_REQ drawing clients (character erase, character draw, obstacle/score painters) post rectangle jobs. The block grants one at a time and walks the granted rectangle in raster order, emitting one pixel per cycle as XOut/YOut/Color/Plot. Clients never drive the VGA adapter directly.

## Interface
- N_REQ, 3, number of requesters (2..8)
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Req  in  N_REQ  per-client job request; held high until that client's Done
- ReqX  in  N_REQ*8  packed top-left X per client (slice i = bits [8i+7:8i])
- ReqY  in  N_REQ*7  packed top-left Y per client
- ReqW  in  N_REQ*4  packed width minus 1 (1..16 pixels)
- ReqH  in  N_REQ*4  packed height minus 1 (1..16 pixels)
- ReqColor  in  N_REQ*3  packed fill colour
- Hold  in  1  freezes pixel walk (no Plot, counters held)
- Grant  out  N_REQ  one-hot, high for the whole job of the winner
- Done  out  N_REQ  one-cycle pulse to the winner when its job finishes
- Busy  out  1  high in any state other than IDLE
- XOut  out  8  pixel X
- YOut  out  7  pixel Y
- Color  out  3  pixel colour
- Plot  out  1  write strobe for XOut/YOut/Color

## Operation
- All outputs are registered. Reset values: XOut=0, YOut=0, Color=0, Plot=0, Grant=0, Done=0, Busy=0, RR pointer=0, state IDLE.
- States: IDLE, FILL, DONE.
- IDLE:
  - Req is sampled only in this state.
  - If any Req bit is set, the arbiter picks a winner, and on the same edge latches its X/Y/W/H/Color, sets Grant, clears xc/yc, and moves to FILL.
- FILL:
  - Each cycle with Hold=0 presents pixel (X0+xc, Y0+yc) with Color.
  - Raster order: xc increments 0..W, then wraps to 0 and yc increments.
  - After pixel (W,H), go to DONE.
  - Hold=1: Plot=0 on the next output, xc/yc frozen, position and colour values held.
- DONE (one cycle): Done[winner]=1, Grant cleared, RR pointer advanced past the winner, return to IDLE.
- Req changes after grant are ignored; the job always completes.
- A client that keeps Req high through Done is eligible again in the next IDLE.
- Clipping:
  - Sums are computed at 9 bits (X) and 8 bits (Y).
  - If X0+xc > 159 or Y0+yc > 119, that cycle has Plot=0, but the walk still advances.
  - XOut/YOut carry the truncated low bits.
- Plot=1 only in FILL with Hold=0 and an on-screen pixel.

## Timing
- Req rises before edge k: Grant valid after edge k.
- First pixel after edge k+1.
- With Hold=0, the last pixel appears after edge k+(W+1)(H+1).
- Done pulses after the following edge.
- Earliest next Grant comes 2 edges after Done (DONE→IDLE→FILL).
- Reset asserted mid-FILL: all outputs and state return to reset values immediately (async), and the job is lost. The client must re-request after Reset deasserts.
- Hold has no effect in IDLE or DONE.

## Configuration
- DRAW_SCHED_RR_EN defined: round-robin arbitration. Search starts at the index after the last winner, so with Req[0] and Req[1] continuously high, grants alternate 0,1,0,1.
- DRAW_SCHED_RR_EN undefined: fixed priority, lowest index wins. The RR pointer is absent, so with Req[0] and Req[1] continuously high, client 0 is always granted.

## Structure
- Package draw_sched_pkg holds:
  - SCREEN_W=160 and SCREEN_H=120
  - coordinate widths X_W=8 and Y_W=7
  - COLOR_W=3
  - state enum {IDLE, FILL, DONE}
  - colour constants COLOR_BG=3'b111 and COLOR_BLACK=3'b000
- One sub-module, rect_walker, holds:
  - xc/yc counters and the Hold gating
  - 9/8-bit address add and clip check
  - last-pixel flag
- The arbiter and FSM stay in draw_scheduler.

## Test plan
- Single job: Req[0] with X=6, Y=102, W=8, H=4, Color=111 → Grant[0] after 1 edge, then 45 Plot pulses in row-major order. First pixel (6,102), row ends at (14,102), last pixel (14,106). Done[0] is one pulse, one cycle after the last Plot.
- Simultaneous Req[0], Req[1], each 1x1, held high, with RR_EN → grant order 0,1,0,1. Without RR_EN → 0,0,0.
- Clipping: X=155, W=15, Y=118, H=3 → 64 FILL cycles. Plot=1 only for x in 155..159 and y in 118..119, giving exactly 10 Plots. Done follows the 64th cycle.
- Hold: during a 4x1 job, raise Hold for 3 cycles after the second pixel → Plot low for 3 cycles, then pixels 3 and 4 with correct coordinates. Done is delayed by 3 cycles.
- Reset mid-FILL of a 9x5 job → all outputs 0 and Busy 0 immediately. After Reset deasserts with Req[2] held, Grant[2] follows and the first pixel is the job's top-left.
- Req[1] dropped mid-job → job still completes its full pixel count, and Done[1] still pulses.
